puzzle_mode_controller: RTL and testbench

Top-level game-mode sequencer for the sliding-puzzle board. It turns a scramble button press into a counted burst of random-move requests to the move generator, then arms the solve phase. When the board reports solved, it drives the buzzer for a fixed time. It sits between the debounced button inputs, the random-move generator and the board-compare logic, and replaces ad-hoc combinational mix/buzz decoding with a single registered FSM.

---
 rtl/puzzle_pkg.sv | 34 +++
 rtl/puzzle_mode_controller_rise_detect.sv | 22 ++
 rtl/puzzle_mode_controller.sv | 114 +++++++++++
 tb/tb_puzzle_mode_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared game-mode definitions for the sliding-puzzle board: FSM encoding,
// default timing constants and the screen codes used by the display logic.
package puzzle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHUFFLE   = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_SOLVE     = 3'd3,
        ST_CELEBRATE = 3'd4
    } game_state_t;

    localparam int SHUFFLE_MOVES_DEF = 31;
    localparam int BUZZ_CYCLES_DEF   = 25_000_000;

    localparam logic [1:0] SCREEN_TITLE = 2'd0;
    localparam logic [1:0] SCREEN_MIX   = 2'd1;
    localparam logic [1:0] SCREEN_PLAY  = 2'd2;
    localparam logic [1:0] SCREEN_WIN   = 2'd3;

    // Screen the display should show for a given game state.
    function automatic logic [1:0] state_screen(game_state_t s);
        logic [1:0] scr;
        scr = SCREEN_TITLE;
        case (s)
            ST_SHUFFLE, ST_SETTLE: scr = SCREEN_MIX;
            ST_SOLVE:              scr = SCREEN_PLAY;
            ST_CELEBRATE:          scr = SCREEN_WIN;
            default:               scr = SCREEN_TITLE;
        endcase
        return scr;
    endfunction

endpackage

// File: rtl/puzzle_mode_controller_rise_detect.sv
// Rising-edge detector for a synchronized button level. The history register
// resets high so a button held through reset release produces no pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/puzzle_mode_controller.sv
// Game-mode sequencer: scramble press -> counted burst of random-move requests
// -> settle -> solve phase -> timed buzzer on a solved board -> idle.
module puzzle_mode_controller
    import puzzle_pkg::*;
#(
    parameter int  SHUFFLE_MOVES = SHUFFLE_MOVES_DEF,
    parameter int  BUZZ_CYCLES   = BUZZ_CYCLES_DEF,
    localparam int CW            = $clog2(SHUFFLE_MOVES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scramble_btn,
    input  logic          solved,
    input  logic          move_ack,
    output logic          rand_req,
    output logic          mix_state,
    output logic          solve_active,
    output logic          buzz,
    output logic [CW-1:0] shuffle_count,
    output logic [2:0]    state_dbg
);

    localparam int            TW        = $clog2(BUZZ_CYCLES + 1);
    localparam logic [CW-1:0] LAST_MOVE = CW'(SHUFFLE_MOVES - 1);
    localparam logic [TW-1:0] BUZZ_LOAD = TW'(BUZZ_CYCLES);

    // rand_req is a level held for the whole shuffle; every cycle with
    // move_ack high while it is up counts as one applied move, so the
    // generator may ack back-to-back at up to one move per cycle.

    game_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rise;

    rise_detect u_scramble_rise (
        .clk   (clk),
        .reset (reset),
        .d     (scramble_btn),
        .pulse (rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    // Outputs depend only on state_q, so no input reaches an output
    // combinationally.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        timer_d      = timer_q;
        rand_req     = 1'b0;
        mix_state    = 1'b0;
        solve_active = 1'b0;
        buzz         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_SHUFFLE;
                    count_d = '0;
                end
            end
            ST_SHUFFLE: begin
                rand_req  = 1'b1;
                mix_state = 1'b1;
                if (move_ack) begin
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_MOVE) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                state_d = ST_SOLVE;
            end
            ST_SOLVE: begin
                solve_active = 1'b1;
                // A solved board beats a simultaneous reshuffle press.
                if (solved) begin
                    state_d = ST_CELEBRATE;
                    timer_d = BUZZ_LOAD;
                end else if (rise) begin
                    state_d = ST_SHUFFLE;
                    count_d = '0;
                end
            end
            ST_CELEBRATE: begin
                buzz = 1'b1;
                if (timer_q <= TW'(1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign shuffle_count = count_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_puzzle_mode_controller.sv
// Directed bench for puzzle_mode_controller with SHUFFLE_MOVES=3, BUZZ_CYCLES=4.
module tb_puzzle_mode_controller;
    import puzzle_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scramble_btn = 1'b0;
    logic       solved = 1'b0;
    logic       move_ack = 1'b0;
    logic       rand_req, mix_state, solve_active, buzz;
    logic [1:0] shuffle_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    puzzle_mode_controller #(.SHUFFLE_MOVES(3), .BUZZ_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .scramble_btn  (scramble_btn),
        .solved        (solved),
        .move_ack      (move_ack),
        .rand_req      (rand_req),
        .mix_state     (mix_state),
        .solve_active  (solve_active),
        .buzz          (buzz),
        .shuffle_count (shuffle_count),
        .state_dbg     (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // {rand_req, mix_state, solve_active, buzz}
    localparam logic [3:0] O_IDLE  = 4'b0000;
    localparam logic [3:0] O_SHUF  = 4'b1100;
    localparam logic [3:0] O_SOLVE = 4'b0010;
    localparam logic [3:0] O_BUZZ  = 4'b0001;

    function automatic logic [3:0] outs();
        return {rand_req, mix_state, solve_active, buzz};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        scramble_btn = 1'b1;
        tick();
        scramble_btn = 1'b0;
    endtask

    task automatic ack_burst(input int n);
        move_ack = 1'b1;
        repeat (n) tick();
        move_ack = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_outs", outs(), O_IDLE);
        check("reset_count", shuffle_count, 0);
        check("reset_state", state_dbg, ST_IDLE);
        tick();
        reset = 1'b0;
        tick();

        // basic flow: three back-to-back acks
        press();
        check("basic_start_outs", outs(), O_SHUF);
        check("basic_start_count", shuffle_count, 0);
        for (int i = 1; i <= 3; i++) exp_q.push_back(2'(i));
        move_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("basic_count", shuffle_count, exp_q.pop_front());
            check("basic_req", outs(), (i < 2) ? O_SHUF : O_IDLE);
        end
        move_ack = 1'b0;
        check("basic_settle_state", state_dbg, ST_SETTLE);
        tick();
        check("basic_solve_outs", outs(), O_SOLVE);
        check("basic_solve_count", shuffle_count, 3);
        tick();
        check("basic_solve_wait", outs(), O_SOLVE);

        // solve -> buzz for four cycles, then idle keeping the count
        solved = 1'b1;
        tick();
        solved = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("buzz_on", outs(), O_BUZZ);
            tick();
        end
        check("buzz_off_outs", outs(), O_IDLE);
        check("buzz_off_state", state_dbg, ST_IDLE);
        check("idle_count_hold", shuffle_count, 3);
        ack_burst(1);
        check("idle_ack_count", shuffle_count, 3);

        // sparse acks, solved and a press during the shuffle are ignored
        press();
        check("sparse_clear", shuffle_count, 0);
        ack_burst(1);
        check("sparse_c1", shuffle_count, 1);
        solved = 1'b1;
        tick();
        solved = 1'b0;
        check("sparse_solved_ignored", outs(), O_SHUF);
        press();
        check("sparse_press_outs", outs(), O_SHUF);
        check("sparse_press_count", shuffle_count, 1);
        tick();
        ack_burst(1);
        check("sparse_c2", shuffle_count, 2);
        tick();
        check("sparse_gap", outs(), O_SHUF);
        ack_burst(1);
        check("sparse_c3", shuffle_count, 3);
        check("sparse_settle", outs(), O_IDLE);
        tick();
        check("sparse_solve", outs(), O_SOLVE);

        // reshuffle from solve
        press();
        check("reshuf_outs", outs(), O_SHUF);
        check("reshuf_count", shuffle_count, 0);
        ack_burst(3);
        tick();
        check("reshuf_solve", outs(), O_SOLVE);

        // press and solved together: solved wins
        scramble_btn = 1'b1;
        solved = 1'b1;
        tick();
        scramble_btn = 1'b0;
        solved = 1'b0;
        check("tie_outs", outs(), O_BUZZ);
        check("tie_state", state_dbg, ST_CELEBRATE);
        tick();
        press();
        check("buzz_press_ignored", outs(), O_BUZZ);
        tick();
        check("buzz_last", outs(), O_BUZZ);
        tick();
        check("tie_idle", outs(), O_IDLE);

        // shuffle leaving the board solved: win at the first solve cycle
        press();
        solved = 1'b1;
        ack_burst(3);
        tick();
        check("win_solve", outs(), O_SOLVE);
        tick();
        check("win_buzz", outs(), O_BUZZ);

        // reset mid-buzz, button held through release
        tick();
        reset = 1'b1;
        scramble_btn = 1'b1;
        solved = 1'b0;
        #2;
        check("rst_buzz_outs", outs(), O_IDLE);
        check("rst_buzz_count", shuffle_count, 0);
        reset = 1'b0;
        tick();
        tick();
        check("held_btn_idle", state_dbg, ST_IDLE);
        check("held_btn_outs", outs(), O_IDLE);
        scramble_btn = 1'b0;
        tick();
        press();
        check("after_release_outs", outs(), O_SHUF);

        // reset mid-shuffle at count 2, then stray acks in idle
        ack_burst(2);
        check("mid_count", shuffle_count, 2);
        #2;
        reset = 1'b1;
        #1;
        check("rst_shuf_outs", outs(), O_IDLE);
        check("rst_shuf_count", shuffle_count, 0);
        reset = 1'b0;
        tick();
        ack_burst(2);
        check("stray_ack_count", shuffle_count, 0);
        check("stray_ack_state", state_dbg, ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
